hazard_ctrl: RTL and testbench

- Parametrised hazard and forwarding controller for the 5-stage MIPS pipeline (IF, ID, EX, MEM, WB).
- Keeps its own registered scoreboard of the instructions in EX, MEM and WB.
- From that scoreboard it produces load-use stalls, branch flushes and EX operand forward selects; all stage modules consume these outputs.
- Adds a no-forwarding mode (stall on every RAW hazard) and saturating performance counters.

---
 rtl/pipe_pkg.sv | 32 +++
 rtl/sat_counter.sv | 19 +
 rtl/hazard_ctrl.sv | 115 +++++++++++
 tb/tb_hazard_ctrl.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared types for the pipeline hazard logic: forward-select codes, the
// scoreboard entry layout and the register-match helper.
package pipe_pkg;

  localparam int REG_AW = 5;
  // Scoreboard entries store register numbers at this width so that any
  // REG_AW up to SB_AW shares the same entry layout (narrower ones zero-extend).
  localparam int SB_AW = 8;

  localparam logic [1:0] FWD_RF  = 2'd0;
  localparam logic [1:0] FWD_MEM = 2'd1;
  localparam logic [1:0] FWD_WB  = 2'd2;

  typedef struct packed {
    logic             v;
    logic [SB_AW-1:0] rs;
    logic [SB_AW-1:0] rt;
    logic             use_rs;
    logic             use_rt;
    logic [SB_AW-1:0] rd;
    logic             regwrite;
    logic             memread;
  } sb_entry_t;

  localparam sb_entry_t SB_BUBBLE = '0;

  // A live producer writing r; register 0 never matches.
  function automatic logic sb_match(input sb_entry_t e, input logic [SB_AW-1:0] r);
    return e.v & e.regwrite & (e.rd == r) & (r != '0);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at its all-ones value instead of wrapping.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard/forwarding controller for the 5-stage pipeline: tracks EX/MEM/WB
// producers and derives load-use stalls, branch flushes and EX forward selects.
module hazard_ctrl #(
  parameter int REG_AW = 5,
  parameter int FWD_EN = 1,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_use_rs,
  input  logic              id_use_rt,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_regwrite,
  input  logic              id_memread,
  input  logic              ex_mem_pcsrc,
  output logic              stall,
  output logic              flush,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  import pipe_pkg::*;

  sb_entry_t        sb_ex, sb_mem, sb_wb;
  sb_entry_t        id_entry;
  logic [SB_AW-1:0] rs_w, rt_w;
  logic             hit_ex, hit_mem, hit_wb;
  logic             raw_stall;
  logic             sb_unused;

  function automatic logic [1:0] fwd_sel(input sb_entry_t mem_e, input sb_entry_t wb_e,
                                         input logic [SB_AW-1:0] r);
    if (sb_match(mem_e, r)) return FWD_MEM;
    if (sb_match(wb_e, r))  return FWD_WB;
    return FWD_RF;
  endfunction

  assign rs_w = SB_AW'(id_rs);
  assign rt_w = SB_AW'(id_rt);

  always_comb begin
    id_entry          = SB_BUBBLE;
    id_entry.v        = 1'b1;
    id_entry.rs       = rs_w;
    id_entry.rt       = rt_w;
    id_entry.use_rs   = id_use_rs;
    id_entry.use_rt   = id_use_rt;
    id_entry.rd       = SB_AW'(id_rd);
    id_entry.regwrite = id_regwrite;
    id_entry.memread  = id_memread;
  end

  assign hit_ex  = (id_use_rs & sb_match(sb_ex, rs_w))  | (id_use_rt & sb_match(sb_ex, rt_w));
  assign hit_mem = (id_use_rs & sb_match(sb_mem, rs_w)) | (id_use_rt & sb_match(sb_mem, rt_w));
  assign hit_wb  = (id_use_rs & sb_match(sb_wb, rs_w))  | (id_use_rt & sb_match(sb_wb, rt_w));

  // With forwarding only a load in EX is too late; without it any in-flight
  // producer blocks the reader until it has left WB.
  always_comb begin
    raw_stall = 1'b0;
    if (FWD_EN != 0) begin
      raw_stall = id_valid & sb_ex.memread & hit_ex;
    end else begin
      raw_stall = id_valid & (hit_ex | hit_mem | hit_wb);
    end
  end

  // A taken branch overrides the stall: the stalled reader is squashed anyway.
  assign flush = ex_mem_pcsrc & ~rst;
  assign stall = raw_stall & ~ex_mem_pcsrc & ~rst;

  always_comb begin
    fwd_a = FWD_RF;
    fwd_b = FWD_RF;
    if ((FWD_EN != 0) && sb_ex.v) begin
      fwd_a = fwd_sel(sb_mem, sb_wb, sb_ex.rs);
      fwd_b = fwd_sel(sb_mem, sb_wb, sb_ex.rt);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sb_ex  <= SB_BUBBLE;
      sb_mem <= SB_BUBBLE;
      sb_wb  <= SB_BUBBLE;
    end else begin
      sb_wb  <= sb_mem;
      sb_mem <= sb_ex;
      sb_ex  <= (stall | flush | ~id_valid) ? SB_BUBBLE : id_entry;
    end
  end

  // Not every entry field is read in every stage.
  assign sb_unused = ^{sb_ex, sb_mem, sb_wb};

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (stall),
    .count (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (flush),
    .count (flush_cnt)
  );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: one forwarding instance and one no-forwarding instance
// with a 2-bit counter, sharing the same ID-stage stimulus.
module tb_hazard_ctrl;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       id_valid, id_use_rs, id_use_rt, id_regwrite, id_memread, ex_mem_pcsrc;
  logic [4:0] id_rs, id_rt, id_rd;

  logic        f_stall, f_flush;
  logic [1:0]  f_fwd_a, f_fwd_b;
  logic [15:0] f_scnt, f_fcnt;
  logic        n_stall, n_flush;
  logic [1:0]  n_fwd_a, n_fwd_b;
  logic [1:0]  n_scnt, n_fcnt;

  hazard_ctrl #(.REG_AW(5), .FWD_EN(1), .CNT_W(16)) dut_f (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_rd(id_rd),
    .id_regwrite(id_regwrite), .id_memread(id_memread), .ex_mem_pcsrc(ex_mem_pcsrc),
    .stall(f_stall), .flush(f_flush), .fwd_a(f_fwd_a), .fwd_b(f_fwd_b),
    .stall_cnt(f_scnt), .flush_cnt(f_fcnt)
  );

  hazard_ctrl #(.REG_AW(5), .FWD_EN(0), .CNT_W(2)) dut_n (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_rd(id_rd),
    .id_regwrite(id_regwrite), .id_memread(id_memread), .ex_mem_pcsrc(ex_mem_pcsrc),
    .stall(n_stall), .flush(n_flush), .fwd_a(n_fwd_a), .fwd_b(n_fwd_b),
    .stall_cnt(n_scnt), .flush_cnt(n_fcnt)
  );

  int n_vec = 0;
  int n_err = 0;
  bit chk_on = 1'b0;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // age[m][k] is the instruction that entered the pipe k+1 edges ago
  // (k=0 is in EX); m=0 is the forwarding instance, m=1 the non-forwarding one.
  typedef struct {
    bit v;
    int rs;
    int rt;
    int rd;
    bit rw;
    bit mr;
  } ins_t;

  ins_t age [2][3];
  int   scnt [2];
  int   fcnt [2];
  int   cmax [2] = '{65535, 3};

  function automatic bit writes(ins_t e, int r);
    return e.v && e.rw && (e.rd == r) && (r != 0);
  endfunction

  function automatic bit model_stall(int m);
    if (rst || !id_valid || ex_mem_pcsrc) return 1'b0;
    for (int k = 0; k < 3; k++) begin
      if (m == 0 && (k > 0 || !age[m][0].mr)) continue;
      if ((id_use_rs && writes(age[m][k], int'(id_rs))) ||
          (id_use_rt && writes(age[m][k], int'(id_rt)))) return 1'b1;
    end
    return 1'b0;
  endfunction

  function automatic logic [1:0] model_fwd(int m, int r);
    if (m == 1 || !age[m][0].v) return 2'd0;
    if (writes(age[m][1], r)) return 2'd1;
    if (writes(age[m][2], r)) return 2'd2;
    return 2'd0;
  endfunction

  // ---------------- scoreboard ----------------
  // Word layout: {stall, flush, fwd_a, fwd_b, stall_cnt[15:0], flush_cnt[15:0]}.
  logic [37:0] exp_q[$];

  always @(posedge clk) begin
    #2;
    if (chk_on) begin
      for (int m = 0; m < 2; m++) begin
        exp_q.push_back({model_stall(m), (ex_mem_pcsrc && !rst),
                         model_fwd(m, age[m][0].rs), model_fwd(m, age[m][0].rt),
                         16'(scnt[m]), 16'(fcnt[m])});
      end
    end
  end

  always @(negedge clk) begin
    logic [37:0] e, a;
    string       p;
    bit          st;
    if (exp_q.size() >= 2) begin
      for (int m = 0; m < 2; m++) begin
        e = exp_q.pop_front();
        if (m == 0) begin
          a = {f_stall, f_flush, f_fwd_a, f_fwd_b, f_scnt, f_fcnt};
          p = "fwd";
        end else begin
          a = {n_stall, n_flush, n_fwd_a, n_fwd_b, 14'd0, n_scnt, 14'd0, n_fcnt};
          p = "nofwd";
        end
        cmp({p, "_stall"},     32'(a[37]),     32'(e[37]));
        cmp({p, "_flush"},     32'(a[36]),     32'(e[36]));
        cmp({p, "_fwd_a"},     32'(a[35:34]),  32'(e[35:34]));
        cmp({p, "_fwd_b"},     32'(a[33:32]),  32'(e[33:32]));
        cmp({p, "_stall_cnt"}, 32'(a[31:16]),  32'(e[31:16]));
        cmp({p, "_flush_cnt"}, 32'(a[15:0]),   32'(e[15:0]));
      end
    end
    // Advance the model to the state the coming edge will produce.
    for (int m = 0; m < 2; m++) begin
      if (rst) begin
        for (int k = 0; k < 3; k++) age[m][k] = '{default: 0};
        scnt[m] = 0;
        fcnt[m] = 0;
      end else begin
        st = model_stall(m);
        if (st && scnt[m] < cmax[m]) scnt[m]++;
        if (ex_mem_pcsrc && fcnt[m] < cmax[m]) fcnt[m]++;
        age[m][2] = age[m][1];
        age[m][1] = age[m][0];
        if (id_valid && !st && !ex_mem_pcsrc)
          age[m][0] = '{1'b1, int'(id_rs), int'(id_rt), int'(id_rd), id_regwrite, id_memread};
        else
          age[m][0] = '{default: 0};
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic set_id(input bit v, input int rs, input int rt, input bit urs, input bit urt,
                        input int rd, input bit rw, input bit mr);
    id_valid = v; id_rs = 5'(rs); id_rt = 5'(rt); id_use_rs = urs; id_use_rt = urt;
    id_rd = 5'(rd); id_regwrite = rw; id_memread = mr;
  endtask

  task automatic idle();
    set_id(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic alu(input int rd, input int rs, input int rt);
    set_id(1, rs, rt, 1, 1, rd, 1, 0);
  endtask

  task automatic load(input int rd, input int base);
    set_id(1, base, 0, 1, 0, rd, 1, 1);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    ex_mem_pcsrc = 1'b0;
    idle();
    step();
    rst = 1'b0;
  endtask

  // ---------------- directed sequences ----------------
  initial begin
    ex_mem_pcsrc = 1'b0;
    idle();
    step();
    step();
    rst = 1'b0;
    chk_on = 1'b1;
    @(negedge clk);
    cmp("rst_stall", 32'(f_stall), 0);
    cmp("rst_flush", 32'(f_flush), 0);
    cmp("rst_fwd_a", 32'(f_fwd_a), 0);
    cmp("rst_fwd_b", 32'(f_fwd_b), 0);
    cmp("rst_stall_cnt", 32'(f_scnt), 0);
    cmp("rst_flush_cnt", 32'(n_fcnt), 0);

    // Load-use: lw $2 then add $3,$2,$4.
    do_reset();
    load(2, 1);
    step();
    alu(3, 2, 4);
    @(negedge clk);
    cmp("lu_stall", 32'(f_stall), 1);
    step();
    @(negedge clk);
    cmp("lu_release", 32'(f_stall), 0);
    cmp("lu_stall_cnt", 32'(f_scnt), 1);
    step();
    idle();
    @(negedge clk);
    cmp("lu_fwd_a", 32'(f_fwd_a), 2);
    cmp("lu_fwd_b", 32'(f_fwd_b), 0);

    // ALU chain: add $5 then sub $6,$5,$5.
    do_reset();
    alu(5, 1, 2);
    step();
    alu(6, 5, 5);
    @(negedge clk);
    cmp("chain_stall", 32'(f_stall), 0);
    cmp("chain_nofwd_stall", 32'(n_stall), 1);
    step();
    idle();
    @(negedge clk);
    cmp("chain_fwd_a", 32'(f_fwd_a), 1);
    cmp("chain_fwd_b", 32'(f_fwd_b), 1);

    // Two producers of $7, reader uses $7 and $0.
    do_reset();
    alu(7, 1, 2);
    step();
    alu(7, 3, 4);
    step();
    set_id(1, 7, 0, 1, 1, 8, 1, 0);
    @(negedge clk);
    cmp("dbl_stall", 32'(f_stall), 0);
    step();
    idle();
    @(negedge clk);
    cmp("dbl_fwd_a", 32'(f_fwd_a), 1);
    cmp("dbl_fwd_b", 32'(f_fwd_b), 0);

    // Taken branch coinciding with a load-use condition.
    do_reset();
    load(2, 1);
    step();
    alu(3, 2, 4);
    ex_mem_pcsrc = 1'b1;
    @(negedge clk);
    cmp("br_flush", 32'(f_flush), 1);
    cmp("br_stall", 32'(f_stall), 0);
    cmp("br_nofwd_stall", 32'(n_stall), 0);
    step();
    ex_mem_pcsrc = 1'b0;
    idle();
    @(negedge clk);
    cmp("br_ex_bubble", 32'(f_fwd_a), 0);
    cmp("br_flush_cnt", 32'(f_fcnt), 1);
    cmp("br_stall_cnt", 32'(f_scnt), 0);
    cmp("br_flush_off", 32'(f_flush), 0);

    // No forwarding: three stall cycles per dependency, counter saturates at 3.
    do_reset();
    alu(9, 1, 2);
    step();
    alu(10, 9, 9);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      cmp("nf_stall", 32'(n_stall), 1);
      cmp("nf_fwd_a", 32'(n_fwd_a), 0);
      step();
    end
    @(negedge clk);
    cmp("nf_release", 32'(n_stall), 0);
    cmp("nf_stall_cnt", 32'(n_scnt), 3);
    step();
    alu(11, 10, 3);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      cmp("nf_stall2", 32'(n_stall), 1);
      cmp("nf_fwd_b", 32'(n_fwd_b), 0);
      step();
    end
    @(negedge clk);
    cmp("nf_release2", 32'(n_stall), 0);
    cmp("nf_cnt_sat", 32'(n_scnt), 3);
    step();
    idle();

    // Reset while a producer of $11 sits in MEM.
    do_reset();
    alu(11, 1, 2);
    step();
    idle();
    step();
    rst = 1'b1;
    alu(12, 11, 11);
    step();
    rst = 1'b0;
    @(negedge clk);
    cmp("mrst_stall", 32'(f_stall), 0);
    cmp("mrst_nofwd_stall", 32'(n_stall), 0);
    cmp("mrst_fwd_a", 32'(f_fwd_a), 0);
    cmp("mrst_flush", 32'(f_flush), 0);
    step();
    idle();
    @(negedge clk);
    cmp("mrst_reader_fwd_a", 32'(f_fwd_a), 0);
    cmp("mrst_reader_fwd_b", 32'(f_fwd_b), 0);

    step();
    step();
    step();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
